// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller that sequences one request at a time through the memory stage.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults instead of aligning them.
module lsu_ctrl #(
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd_in,
  output logic        mem_stall,
  output logic [2:0]  mem_opcode,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd
);

  localparam logic [2:0] OP_IDLE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        accept;
  logic [2:0]  op_dec;
  logic        op_ok;
  logic [1:0]  size_log2;
  logic        fault;
  logic [11:0] addr_clr_mask;
  logic [11:0] addr_eff;

  logic [2:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [4:0]  rd_reg;
  logic        load_reg;

  logic        mem_stall_reg;
  logic [2:0]  mem_opcode_reg;
  logic [11:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_data_reg;
  logic [4:0]  resp_rd_reg;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && (state_reg == ST_IDLE);

  // Class/funct3 decode; op_ok is false for both-or-neither class and for unmapped funct3.
  always_comb begin
    op_dec    = 3'b000;
    op_ok     = 1'b0;
    size_log2 = 2'd0;
    if (is_load && !is_store) begin
      case (funct3)
        3'b000:  begin op_dec = 3'b000; op_ok = 1'b1; size_log2 = 2'd0; end
        3'b001:  begin op_dec = 3'b001; op_ok = 1'b1; size_log2 = 2'd1; end
        3'b010:  begin op_dec = 3'b010; op_ok = 1'b1; size_log2 = 2'd2; end
        3'b100:  begin op_dec = 3'b110; op_ok = 1'b1; size_log2 = 2'd0; end
        3'b101:  begin op_dec = 3'b111; op_ok = 1'b1; size_log2 = 2'd1; end
        default: begin op_dec = 3'b000; op_ok = 1'b0; size_log2 = 2'd0; end
      endcase
    end else if (is_store && !is_load) begin
      case (funct3)
        3'b000:  begin op_dec = 3'b011; op_ok = 1'b1; size_log2 = 2'd0; end
        3'b001:  begin op_dec = 3'b100; op_ok = 1'b1; size_log2 = 2'd1; end
        3'b010:  begin op_dec = 3'b101; op_ok = 1'b1; size_log2 = 2'd2; end
        default: begin op_dec = 3'b000; op_ok = 1'b0; size_log2 = 2'd0; end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  always_comb begin
    misalign      = ((size_log2 == 2'd1) && addr[0]) ||
                    ((size_log2 == 2'd2) && (addr[1:0] != 2'b00));
    fault         = !op_ok || (addr[31:12] != 20'd0) || misalign;
    addr_clr_mask = 12'd0;
  end
`else
  // Without trapping, the offending low bits are simply dropped.
  always_comb begin
    fault         = !op_ok || (addr[31:12] != 20'd0);
    addr_clr_mask = {10'd0, (size_log2 == 2'd2), (size_log2 != 2'd0)};
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_addr_eff
      assign addr_eff[gi] = addr[gi] & ~addr_clr_mask[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (fault) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_ACCESS;
            cnt_next   = is_load ? 3'(RD_LAT) : 3'(WR_LAT);
          end
        end
      end
      ST_ACCESS: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg <= 3'd1) begin
          state_next = ST_RESP;
          cnt_next   = 3'd0;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd0;
      op_reg         <= 3'd0;
      addr_reg       <= 12'd0;
      wdata_reg      <= 32'd0;
      rd_reg         <= 5'd0;
      load_reg       <= 1'b0;
      mem_stall_reg  <= 1'b1;
      mem_opcode_reg <= OP_IDLE;
      mem_addr_reg   <= 12'd0;
      mem_wdata_reg  <= 32'd0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_data_reg  <= 32'd0;
      resp_rd_reg    <= 5'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        op_reg    <= op_dec;
        addr_reg  <= addr_eff;
        wdata_reg <= st_data;
        rd_reg    <= rd_in;
        load_reg  <= is_load;
      end

      mem_stall_reg <= (state_next != ST_ACCESS);
      if (state_next == ST_ACCESS) begin
        mem_opcode_reg <= accept ? op_dec   : op_reg;
        mem_addr_reg   <= accept ? addr_eff : addr_reg;
        mem_wdata_reg  <= accept ? st_data  : wdata_reg;
      end else begin
        mem_opcode_reg <= OP_IDLE;
        mem_addr_reg   <= 12'd0;
        mem_wdata_reg  <= 32'd0;
      end

      resp_valid_reg <= (state_next == ST_RESP);
      resp_err_reg   <= (state_next == ST_RESP) && accept && fault;
      if (state_next == ST_RESP)
        resp_rd_reg <= accept ? rd_in : rd_reg;
      else
        resp_rd_reg <= 5'd0;
      // Load data is taken on the last ACCESS edge; the memory stage has already extended it.
      if ((state_next == ST_RESP) && (state_reg == ST_ACCESS) && load_reg)
        resp_data_reg <= mem_rdata;
      else
        resp_data_reg <= 32'd0;
    end
  end

  assign mem_stall  = mem_stall_reg;
  assign mem_opcode = mem_opcode_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_data  = resp_data_reg;
  assign resp_rd    = resp_rd_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized requests against a table-driven reference model.
module tb_lsu_ctrl;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic        CLK;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [4:0]  rd_in;
  logic        mem_stall;
  logic [2:0]  mem_opcode;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .addr(addr), .st_data(st_data), .rd_in(rd_in),
    .mem_stall(mem_stall), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_data(resp_data), .resp_rd(resp_rd)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: opcode table, access size in bytes, and the resulting address/fault.
  task automatic model(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       output bit flt, output logic [2:0] op, output logic [11:0] ma, output int lat);
    int size;
    flt  = 1'b0;
    op   = 3'b000;
    size = 1;
    if (ld == st) flt = 1'b1;
    else if (ld) begin
      case (f3)
        3'd0: begin op = 3'd0; size = 1; end
        3'd1: begin op = 3'd1; size = 2; end
        3'd2: begin op = 3'd2; size = 4; end
        3'd4: begin op = 3'd6; size = 1; end
        3'd5: begin op = 3'd7; size = 2; end
        default: flt = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0: begin op = 3'd3; size = 1; end
        3'd1: begin op = 3'd4; size = 2; end
        3'd2: begin op = 3'd5; size = 4; end
        default: flt = 1'b1;
      endcase
    end
    if (a >= 32'h1000) flt = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % size) != 0) flt = 1'b1;
    ma = 12'(a);
`else
    ma = 12'(a - (a % size));
`endif
    lat = ld ? RD_LAT : WR_LAT;
  endtask

  // Runs one request from an idle negedge through RESP and back to idle.
  task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata);
    bit          flt;
    logic [2:0]  op;
    logic [11:0] ma;
    int          lat;
    logic [31:0] exp_data;
    model(ld, st, f3, a, flt, op, ma, lat);
    exp_data = (!flt && ld) ? rdata : 32'd0;

    chk("idle_ready", req_ready, 1);
    chk("idle_stall", mem_stall, 1);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; st_data = sd; rd_in = rd; mem_rdata = $urandom;
    @(negedge CLK);
    req_valid = 1'b0;
    is_load = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; st_data = $urandom; rd_in = 5'($urandom);
    if (!flt) begin
      for (int k = 1; k <= lat; k++) begin
        chk("acc_stall", mem_stall, 0);
        chk("acc_opcode", mem_opcode, op);
        chk("acc_addr", mem_addr, ma);
        chk("acc_wdata", mem_wdata, sd);
        chk("acc_resp_valid", resp_valid, 0);
        chk("acc_ready", req_ready, 0);
        mem_rdata = (k == lat) ? rdata : ~rdata;
        @(negedge CLK);
      end
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, flt);
    chk("resp_data", resp_data, exp_data);
    chk("resp_rd", resp_rd, rd);
    chk("resp_stall", mem_stall, 1);
    chk("resp_opcode", mem_opcode, 3'b010);
    chk("resp_addr", mem_addr, 0);
    chk("resp_ready", req_ready, 0);
    @(negedge CLK);
    chk("post_valid", resp_valid, 0);
    chk("post_ready", req_ready, 1);
    chk("post_data", resp_data, 0);
    chk("post_err", resp_err, 0);
    $display("txn ld=%0d st=%0d f3=%0d addr=%h rd=%0d -> err=%0d data=%h", ld, st, f3, a, rd,
             resp_err, resp_data);
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; st_data = 32'd0; rd_in = 5'd0; mem_rdata = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_stall", mem_stall, 1);
    chk("rst_opcode", mem_opcode, 3'b010);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_rd", resp_rd, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ready", req_ready, 1);

    txn(1, 0, 3'b010, 32'h404, 32'h0, 5'd7, 32'hDEADBEEF);
    txn(0, 1, 3'b001, 32'h802, 32'h1234, 5'd9, 32'hCAFEF00D);
    txn(1, 0, 3'b010, 32'h1000, 32'h0, 5'd3, 32'h11111111);
    txn(1, 0, 3'b001, 32'h003, 32'h0, 5'd4, 32'h0000ABCD);
    txn(0, 1, 3'b010, 32'hFFF, 32'h55AA55AA, 5'd31, 32'h0);
    txn(1, 1, 3'b000, 32'h010, 32'h0, 5'd1, 32'h0);
    txn(0, 0, 3'b000, 32'h010, 32'h0, 5'd2, 32'h0);
    txn(0, 1, 3'b011, 32'h010, 32'h0, 5'd5, 32'h0);
    txn(1, 0, 3'b110, 32'h010, 32'h0, 5'd6, 32'h0);

    // Request held valid continuously: accepts only from IDLE, stall gap between ACCESS windows.
    req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010;
    addr = 32'h010; st_data = 32'hA5A5A5A5; rd_in = 5'd8;
    for (int i = 0; i < 3 * (WR_LAT + 2); i++) begin
      int ph;
      ph = i % (WR_LAT + 2);
      chk("b2b_ready", req_ready, (ph == 0));
      chk("b2b_stall", mem_stall, !(ph >= 1 && ph <= WR_LAT));
      chk("b2b_valid", resp_valid, (ph == WR_LAT + 1));
      @(negedge CLK);
    end
    req_valid = 1'b0;
    $display("txn back-to-back SW x3 done");

    // Reset in the second ACCESS cycle of a load abandons it.
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h020; rd_in = 5'd12;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rstacc_stall1", mem_stall, 0);
    @(negedge CLK);
    chk("rstacc_stall2", mem_stall, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("rstacc_stall_after", mem_stall, 1);
    chk("rstacc_valid", resp_valid, 0);
    chk("rstacc_opcode", mem_opcode, 3'b010);
    RST = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      @(negedge CLK);
      chk("rstacc_ready", req_ready, 1);
      chk("rstacc_noresp", resp_valid, 0);
    end
    $display("txn reset during ACCESS done");

    for (int n = 0; n < 40; n++) begin
      bit          ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          cls;
      cls = $urandom_range(0, 9);
      ld  = (cls < 5) || (cls == 9);
      st  = ((cls >= 5) && (cls < 8)) || (cls == 9);
      f3  = 3'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'hFFF));
      txn(ld, st, f3, a, $urandom, 5'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter RD_LAT, default 4, ACCESS cycles for a load; legal range 1..7.
REQ-002 Parameter WR_LAT, default 2, ACCESS cycles for a store; legal range 1..7.
REQ-003 CLK  in  1  single clock; all state on posedge CLK.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  pipeline presents a memory instruction.
REQ-006 req_ready  out  1  lsu accepts request; high only in IDLE.
REQ-007 is_load / is_store  in  1 each  instruction class.
REQ-008 funct3  in  3  RISC-V funct3 of the load/store.
REQ-009 addr  in  32  effective byte address.
REQ-010 st_data  in  32  store data.
REQ-011 rd_in  in  5  destination register.
REQ-012 mem_stall  out  1  memory stage stall; 1 = no operation.
REQ-013 mem_opcode  out  3  memory stage opcode.
REQ-014 mem_addr  out  12  memory stage byte address.
REQ-015 mem_wdata  out  32  memory stage write data.
REQ-016 mem_rdata  in  32  read data returned by memory stage.
REQ-017 resp_valid  out  1  one-cycle completion pulse.
REQ-018 resp_err  out  1  request faulted; no memory access performed.
REQ-019 resp_data  out  32  load result; 0 for stores and faults.
REQ-020 resp_rd  out  5  destination register of completed request.

Function
REQ-021 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accepted legal request, IDLE->RESP on accepted faulting request, ACCESS->RESP when counter reaches 1, RESP->IDLE unconditionally.
REQ-022 Request accepted when req_valid & req_ready; addr, st_data, rd_in, funct3 and class are registered at acceptance.
REQ-023 Opcode map: load 000->000, 001->001, 010->010, 100->110, 101->111; store 000->011, 001->100, 010->101.
REQ-024 Fault conditions: both or neither of is_load/is_store; unmapped funct3; addr[31:12] != 0; misalignment (REQ-035).
REQ-025 mem_stall = 0 only in ACCESS; 1 in IDLE, RESP and reset, guaranteeing at least one stall cycle between consecutive accesses.
REQ-026 In ACCESS, mem_opcode, mem_addr = addr[11:0], and mem_wdata = st_data are registered and held stable for every ACCESS cycle.
REQ-027 Outside ACCESS, mem_opcode = 3'b010 (read, no write), mem_addr = 0, mem_wdata = 0.
REQ-028 A 3-bit counter loads RD_LAT or WR_LAT on entering ACCESS and decrements each ACCESS cycle; ACCESS lasts exactly RD_LAT or WR_LAT cycles.
REQ-029 For loads, mem_rdata is captured in the last ACCESS cycle and presented on resp_data in RESP; no sign or zero extension is applied, because the memory stage already extends.
REQ-030 resp_valid = 1 only in RESP; resp_rd, resp_err, resp_data are valid with it and are 0 otherwise.
REQ-031 Request-to-response latency: legal load 1+RD_LAT cycles, legal store 1+WR_LAT cycles, fault 1 cycle; req_ready returns one cycle after resp_valid.
REQ-032 req_valid asserted while req_ready = 0 is ignored; the source holds it until accepted.

Reset
REQ-033 With RST = 1 at a posedge: state = IDLE, counter = 0, all registered outputs 0, and mem_stall = 1, mem_opcode = 3'b010.
REQ-034 RST in ACCESS or RESP abandons the request: no resp_valid is produced for it, and mem_stall is 1 from the next cycle.

Configuration
REQ-035 LSU_MISALIGN_TRAP_EN defined: halfword with addr[0] = 1 or word with addr[1:0] != 0 faults (resp_err = 1, no access); undefined: low address bits are cleared (halfword addr[0], word addr[1:0]) and the access proceeds without fault.

Verification
REQ-036 LW addr 0x404, mem_rdata 0xDEADBEEF in last ACCESS cycle -> opcode 010, mem_addr 0x404, resp_valid 5 cycles after accept, resp_data 0xDEADBEEF, resp_err 0.
REQ-037 SH funct3 001, addr 0x802, st_data 0x1234 -> mem_opcode 100 held 2 cycles with mem_stall 0; resp_valid at cycle 3, resp_data 0.
REQ-038 LW addr 0x1000 -> resp_valid next cycle, resp_err 1, mem_stall never 0.
REQ-039 LH addr 0x003 -> with LSU_MISALIGN_TRAP_EN, resp_err 1; without it, mem_addr 0x002 and opcode 001.
REQ-040 Back-to-back requests held valid -> second accepted only after RESP; at least one mem_stall = 1 cycle between the two ACCESS windows.
REQ-041 RST pulsed in the 2nd ACCESS cycle of a load -> no resp_valid, mem_stall 1 next cycle, req_ready 1 the cycle after RST deasserts.
